// File: rtl/axil_cmd_master.sv
// AXI4-Lite single-outstanding master: turns valid/ready commands into
// AW/W/B or AR/R transactions and returns the response on a rsp port.
module axil_cmd_master #(
    parameter int         ADDR_WIDTH  = 7,
    parameter int         DATA_WIDTH  = 32,
    parameter logic [2:0] PROT        = 3'b000,
    parameter int         HANG_CYCLES = 256
) (
    input  logic                      M_AXI_ACLK,
    input  logic                      M_AXI_ARESET,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      rsp_write,
    output logic                      bus_hang,
    output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                M_AXI_AWPROT,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                M_AXI_ARPROT,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = $clog2(HANG_CYCLES + 1);
    localparam logic [CNT_W-1:0] HANG_MAX = CNT_W'(HANG_CYCLES);

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP
    } state_t;

    state_t                state_q, state_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            resp_q, resp_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  hang_q, hang_d;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, busy, progress;

    // All VALID/READY outputs decode registered state only.
    assign cmd_ready     = (state_q == IDLE);
    assign rsp_valid     = (state_q == RSP);
    assign M_AXI_AWVALID = (state_q == WR_REQ) && !aw_done_q;
    assign M_AXI_WVALID  = (state_q == WR_REQ) && !w_done_q;
    assign M_AXI_BREADY  = (state_q == WR_RESP);
    assign M_AXI_ARVALID = (state_q == RD_REQ);
    assign M_AXI_RREADY  = (state_q == RD_RESP);

    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_ARADDR = addr_q;
    assign M_AXI_AWPROT = PROT;
    assign M_AXI_ARPROT = PROT;
    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_WSTRB  = wstrb_q;

    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;
    assign rsp_write = write_q;
    assign bus_hang  = hang_q;

    assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;
    assign b_hs  = M_AXI_BREADY && M_AXI_BVALID;
    assign ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
    assign r_hs  = M_AXI_RREADY && M_AXI_RVALID;

    assign busy = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                  (state_q == RD_REQ) || (state_q == RD_RESP);
    assign progress = aw_hs || w_hs || b_hs || ar_hs || r_hs;

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            write_q   <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= '0;
            cnt_q     <= '0;
            hang_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            write_q   <= write_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            cnt_q     <= cnt_d;
            hang_q    <= hang_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        write_d   = write_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        cnt_d     = cnt_q;
        hang_d    = hang_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                    write_d   = cmd_write;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = cmd_write ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                // AW and W may finish in either order or together.
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                if (aw_done_d && w_done_d) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    resp_d  = M_AXI_BRESP;
                    rdata_d = '0;
                    state_d = RSP;
                end
            end
            RD_REQ: begin
                if (ar_hs) begin
                    state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                if (r_hs) begin
                    rdata_d = M_AXI_RDATA;
                    resp_d  = M_AXI_RRESP;
                    state_d = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Stall watchdog: saturating, flags only, never aborts.
        if (!busy || (state_d != state_q) || progress) begin
            cnt_d = '0;
        end else if (cnt_q != HANG_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (busy && (cnt_d == HANG_MAX)) begin
            hang_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master with a small AXI4-Lite slave model
// and a response scoreboard.
module tb_axil_cmd_master;

    logic        clk = 1'b0;
    logic        areset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [6:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write, bus_hang;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [6:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, arvalid, arready, rvalid, rready;

    always #5 clk = ~clk;

    axil_cmd_master #(
        .ADDR_WIDTH(7), .DATA_WIDTH(32), .PROT(3'b000), .HANG_CYCLES(256)
    ) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .rsp_write(rsp_write), .bus_hang(bus_hang),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot),
        .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid),
        .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot),
        .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
        .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    // Slave model with programmable AW/AR stalls and B hold-off.
    int          aw_stall = 0, ar_stall = 0;
    int          aw_wait, ar_wait;
    logic        b_hold = 1'b0;
    logic [1:0]  slv_bresp = 2'b00, slv_rresp = 2'b00;
    logic        aw_got, w_got;
    logic [6:0]  aw_addr_l;
    logic [31:0] w_data_l;
    logic [3:0]  w_strb_l;
    logic [31:0] mem [32];
    logic        aw_hs, w_hs, aw_got_n, w_got_n;
    logic [6:0]  addr_eff;
    logic [31:0] data_eff;
    logic [3:0]  strb_eff;

    assign awready  = awvalid && (aw_wait >= aw_stall);
    assign wready   = 1'b1;
    assign arready  = arvalid && (ar_wait >= ar_stall);
    assign aw_hs    = awvalid && awready;
    assign w_hs     = wvalid && wready;
    assign aw_got_n = aw_got || aw_hs;
    assign w_got_n  = w_got || w_hs;
    assign addr_eff = aw_hs ? awaddr : aw_addr_l;
    assign data_eff = w_hs ? wdata : w_data_l;
    assign strb_eff = w_hs ? wstrb : w_strb_l;

    always @(posedge clk) begin
        if (areset) begin
            aw_wait <= 0; ar_wait <= 0;
            aw_got <= 1'b0; w_got <= 1'b0;
            bvalid <= 1'b0; rvalid <= 1'b0;
            bresp <= 2'b00; rresp <= 2'b00; rdata <= '0;
            aw_addr_l <= '0; w_data_l <= '0; w_strb_l <= '0;
        end else begin
            if (awvalid && !awready) aw_wait <= aw_wait + 1;
            else if (aw_hs) aw_wait <= 0;
            if (arvalid && !arready) ar_wait <= ar_wait + 1;
            else if (arvalid && arready) ar_wait <= 0;
            if (aw_hs) aw_addr_l <= awaddr;
            if (w_hs) begin
                w_data_l <= wdata;
                w_strb_l <= wstrb;
            end
            if (aw_got_n && w_got_n && !bvalid && !b_hold) begin
                bvalid <= 1'b1;
                bresp  <= slv_bresp;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                for (int b = 0; b < 4; b++)
                    if (strb_eff[b])
                        mem[addr_eff[6:2]][8*b +: 8] <= data_eff[8*b +: 8];
            end else begin
                aw_got <= aw_got_n;
                w_got  <= w_got_n;
                if (bvalid && bready) bvalid <= 1'b0;
            end
            if (arvalid && arready) begin
                rvalid <= 1'b1;
                rdata  <= mem[araddr[6:2]];
                rresp  <= slv_rresp;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        write;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;
    exp_t sbq[$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic w, input logic [31:0] d,
                            input logic [1:0] r);
        exp_t e;
        e.write = w; e.rdata = d; e.resp = r;
        sbq.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the handshake.
    task automatic send_cmd(input logic w, input logic [6:0] a,
                            input logic [31:0] d, input logic [3:0] s,
                            output int hs_cyc);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a;
        cmd_wdata = d; cmd_wstrb = s;
        hs_cyc = -1;
        for (int i = 0; i < 1000; i++) begin
            if (cmd_ready) begin
                hs_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (hs_cyc < 0) chk("cmd_timeout", 64'd0, 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input string tag, input int hs_cyc,
                           input int exp_lat);
        exp_t e;
        int   seen;
        seen = 0;
        for (int i = 0; i < 1000; i++) begin
            if (rsp_valid) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        if (seen == 0 || sbq.size() == 0) begin
            chk({tag, "_rsp_timeout"}, 64'd0, 64'd1);
        end else begin
            e = sbq.pop_front();
            chk({tag, "_write"}, rsp_write, e.write);
            chk({tag, "_rdata"}, rsp_rdata, e.rdata);
            chk({tag, "_resp"}, rsp_resp, e.resp);
            if (exp_lat > 0) chk({tag, "_lat"}, cyc - hs_cyc, exp_lat);
        end
        @(negedge clk);
    endtask

    initial begin
        int   hs;
        exp_t e;
        areset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_hang", bus_hang, 1'b0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        areset = 1'b0;
        @(negedge clk);

        // Zero-wait write: AW and W together, then B.
        push_exp(1'b1, 32'h0, 2'b00);
        send_cmd(1'b1, 7'h0C, 32'hDEADBEEF, 4'hF, hs);
        chk("wr_aw_w_same", {awvalid, wvalid}, 2'b11);
        chk("wr_awaddr", awaddr, 7'h0C);
        chk("wr_wdata", wdata, 32'hDEADBEEF);
        @(negedge clk);
        chk("wr_valids_drop", {awvalid, wvalid}, 2'b00);
        chk("wr_bready", bready, 1'b1);
        get_rsp("wr0", hs, 3);
        chk("wr0_cmd_ready", cmd_ready, 1'b1);

        // Zero-wait read back.
        push_exp(1'b0, 32'hDEADBEEF, 2'b00);
        send_cmd(1'b0, 7'h0C, 32'h0, 4'h0, hs);
        chk("rd_arvalid", arvalid, 1'b1);
        chk("rd_araddr", araddr, 7'h0C);
        get_rsp("rd0", hs, 3);

        // AWREADY stalled 5 cycles, WREADY immediate, slave error resp.
        aw_stall = 5; slv_bresp = 2'b10;
        push_exp(1'b1, 32'h0, 2'b10);
        send_cmd(1'b1, 7'h10, 32'h12345678, 4'hF, hs);
        for (int i = 0; i < 6; i++) begin
            chk("st_awvalid", awvalid, 1'b1);
            chk("st_awaddr", awaddr, 7'h10);
            chk("st_wvalid", wvalid, (i == 0));
            chk("st_bready", bready, 1'b0);
            @(negedge clk);
        end
        chk("st_aw_drop", awvalid, 1'b0);
        chk("st_bready_on", bready, 1'b1);
        get_rsp("wr_stall", hs, 8);
        aw_stall = 0; slv_bresp = 2'b00;

        // Consumer back-pressure; second command must wait.
        rsp_ready = 1'b0;
        push_exp(1'b0, 32'h12345678, 2'b00);
        send_cmd(1'b0, 7'h10, 32'h0, 4'h0, hs);
        for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
        chk("bp_rsp_seen", rsp_valid, 1'b1);
        e = sbq.pop_front();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 7'h14;
        cmd_wdata = 32'hA5A5_0F0F; cmd_wstrb = 4'h3;
        for (int i = 0; i < 10; i++) begin
            chk("bp_rsp_valid", rsp_valid, 1'b1);
            chk("bp_rsp_rdata", rsp_rdata, e.rdata);
            chk("bp_rsp_write", rsp_write, e.write);
            chk("bp_cmd_ready", cmd_ready, 1'b0);
            chk("bp_no_aw", awvalid, 1'b0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_rsp_drop", rsp_valid, 1'b0);
        chk("bp_cmd_ready_back", cmd_ready, 1'b1);
        push_exp(1'b1, 32'h0, 2'b00);
        send_cmd(1'b1, 7'h14, 32'hA5A5_0F0F, 4'h3, hs);
        chk("bp_next_aw", awvalid, 1'b1);
        chk("bp_next_addr", awaddr, 7'h14);
        chk("bp_next_strb", wstrb, 4'h3);
        get_rsp("wr_bp", hs, 3);

        // ARREADY stalled 300 cycles: hang flag at wait cycle 256.
        ar_stall = 300;
        push_exp(1'b0, 32'hDEADBEEF, 2'b00);
        send_cmd(1'b0, 7'h0C, 32'h0, 4'h0, hs);
        repeat (255) @(negedge clk);
        chk("hang_pre", bus_hang, 1'b0);
        chk("hang_arvalid", arvalid, 1'b1);
        @(negedge clk);
        chk("hang_set", bus_hang, 1'b1);
        chk("hang_arvalid_held", arvalid, 1'b1);
        get_rsp("rd_hang", hs, 0);
        chk("hang_sticky", bus_hang, 1'b1);
        ar_stall = 0;

        // Reset during WR_RESP drops everything, no response.
        b_hold = 1'b1;
        send_cmd(1'b1, 7'h18, 32'h0BAD_F00D, 4'hF, hs);
        @(negedge clk);
        chk("mr_bready", bready, 1'b1);
        areset = 1'b1;
        @(negedge clk);
        chk("mr_bready_drop", bready, 1'b0);
        chk("mr_cmd_ready", cmd_ready, 1'b1);
        chk("mr_hang_clr", bus_hang, 1'b0);
        chk("mr_rsp_valid", rsp_valid, 1'b0);
        areset = 1'b0; b_hold = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("mr_no_rsp", rsp_valid, 1'b0);
        end

        push_exp(1'b0, 32'hDEADBEEF, 2'b00);
        send_cmd(1'b0, 7'h0C, 32'h0, 4'h0, hs);
        get_rsp("rd_after_rst", hs, 3);
        chk("sb_empty", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
